// File: rtl/mc_sequencer_if.sv
// Control/status bundle between the multi-cycle sequencer and its environment.
// The master drives run, IR fields and memory ready; the slave (sequencer) reports state and events.
interface mc_sequencer_if;
    logic        run;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        mem_ready;
    logic [5:0]  state;
    logic        stall;
    logic        instr_done;
    logic        illegal;
    logic [15:0] retired;

    modport master (
        output run,
        output opcode,
        output funct,
        output mem_ready,
        input  state,
        input  stall,
        input  instr_done,
        input  illegal,
        input  retired
    );

    modport slave (
        input  run,
        input  opcode,
        input  funct,
        input  mem_ready,
        output state,
        output stall,
        output instr_done,
        output illegal,
        output retired
    );
endinterface

// File: rtl/mc_sequencer.sv
// Multi-cycle instruction sequencer: walks IF/ID/EXEC/MEM/WB per opcode class,
// flags stalls, completions and illegal instructions, and counts retired instructions.
module mc_sequencer (
    input  logic          clk,
    input  logic          reset,
    mc_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_ID   = 3'd0,
        ST_IF   = 3'd1,
        ST_EXEC = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    typedef enum logic [3:0] {
        CL_LW,
        CL_SW,
        CL_J,
        CL_JAL,
        CL_BR,
        CL_IMM,
        CL_RALU,
        CL_JR,
        CL_ILL
    } class_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    state_t      state_q;
    state_t      state_d;
    state_t      end_state;
    class_t      cls;
    logic        stall;
    logic        done;
    logic        ill;
    logic        mem_class;
    logic [15:0] retired_q;

    // IR is decoded continuously; the environment keeps it stable from ID until end
    always_comb begin
        cls = CL_ILL;
        case (bus.opcode)
            OP_LW:   cls = CL_LW;
            OP_SW:   cls = CL_SW;
            OP_J:    cls = CL_J;
            OP_JAL:  cls = CL_JAL;
            OP_BEQ,
            OP_BNE:  cls = CL_BR;
            OP_ADDI,
            OP_XORI: cls = CL_IMM;
            OP_RTYPE: begin
                case (bus.funct)
                    FN_ADD,
                    FN_SUB,
                    FN_SLT:  cls = CL_RALU;
                    FN_JR:   cls = CL_JR;
                    default: cls = CL_ILL;
                endcase
            end
            default: cls = CL_ILL;
        endcase
    end

    always_comb begin
        end_state = bus.run ? ST_IF : ST_HALT;
        mem_class = (cls == CL_LW) || (cls == CL_SW);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_HALT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        stall = 1'b0;
        done  = 1'b0;
        ill   = 1'b0;
        case (state_q)
            ST_IF: begin
                stall = !bus.mem_ready;
            end
            ST_ID: begin
                done = (cls == CL_J);
                ill  = (cls == CL_ILL);
            end
            ST_EXEC: begin
                done = (cls == CL_JR);
            end
            ST_MEM: begin
                // Only data accesses wait on memory; the branch MEM slot is a fixed single cycle
                if (mem_class) begin
                    stall = !bus.mem_ready;
                    done  = (cls == CL_SW) && bus.mem_ready;
                end
            end
            ST_WB: begin
                done = (cls inside {CL_LW, CL_BR, CL_JAL, CL_IMM, CL_RALU});
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALT: begin
                if (bus.run) state_d = ST_IF;
            end
            ST_IF: begin
                if (bus.mem_ready) state_d = ST_ID;
            end
            ST_ID: begin
                if (done || ill) state_d = end_state;
                else             state_d = ST_EXEC;
            end
            ST_EXEC: begin
                case (cls)
                    CL_LW, CL_SW, CL_BR:      state_d = ST_MEM;
                    CL_JAL, CL_IMM, CL_RALU:  state_d = ST_WB;
                    default:                  state_d = end_state;
                endcase
            end
            ST_MEM: begin
                if (stall) begin
                    state_d = ST_MEM;
                end else begin
                    case (cls)
                        CL_LW, CL_BR: state_d = ST_WB;
                        default:      state_d = end_state;
                    endcase
                end
            end
            ST_WB: begin
                state_d = end_state;
            end
            default: begin
                state_d = ST_HALT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
        end else if (done) begin
            retired_q <= retired_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert ($onehot0({stall, done, ill}))
                else $error("stall/instr_done/illegal overlap");
        end
    end

    assign bus.state      = {3'b000, state_q};
    assign bus.stall      = stall;
    assign bus.instr_done = done;
    assign bus.illegal    = ill;
    assign bus.retired    = retired_q;

endmodule

// File: tb/tb_mc_sequencer.sv
// Self-checking bench for mc_sequencer: per-cycle expectations are queued as stimulus
// is driven and compared on the falling edge.
module tb_mc_sequencer;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BAD   = 6'b111111;
    localparam logic [5:0] FN_JR    = 6'b001000;
    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SLT   = 6'b101010;

    localparam int K_ILL = 0;
    localparam int K_LW  = 1;
    localparam int K_SW  = 2;
    localparam int K_J   = 3;
    localparam int K_JAL = 4;
    localparam int K_BR  = 5;
    localparam int K_ALU = 6;
    localparam int K_JR  = 7;

    typedef struct packed {
        logic [5:0]  st;
        logic        stall;
        logic        done;
        logic        ill;
        logic [15:0] ret;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] exp_ret;
    exp_t        sb[$];
    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    always #5 clk = ~clk;

    mc_sequencer_if bus ();

    mc_sequencer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("state",      {26'd0, bus.state},      {26'd0, e.st});
            chk("stall",      {31'd0, bus.stall},      {31'd0, e.stall});
            chk("instr_done", {31'd0, bus.instr_done}, {31'd0, e.done});
            chk("illegal",    {31'd0, bus.illegal},    {31'd0, e.ill});
            chk("retired",    {16'd0, bus.retired},    {16'd0, e.ret});
        end
    end

    function automatic int kind(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            OP_LW:            return K_LW;
            OP_SW:            return K_SW;
            OP_J:             return K_J;
            OP_JAL:           return K_JAL;
            OP_BEQ, OP_BNE:   return K_BR;
            OP_ADDI, OP_XORI: return K_ALU;
            OP_RTYPE: begin
                case (fn)
                    FN_ADD, FN_SUB, FN_SLT: return K_ALU;
                    FN_JR:                  return K_JR;
                    default:                return K_ILL;
                endcase
            end
            default:          return K_ILL;
        endcase
    endfunction

    // Drive one cycle of inputs and queue what the outputs must show during it
    task automatic cyc(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic mr,
                       input logic [5:0] est, input logic es, input logic ed, input logic ei);
        bus.run       = r;
        bus.opcode    = op;
        bus.funct     = fn;
        bus.mem_ready = mr;
        sb.push_back('{st: est, stall: es, done: ed, ill: ei, ret: exp_ret});
        if (ed) exp_ret = exp_ret + 16'd1;
        @(posedge clk);
        #1;
    endtask

    // One instruction starting in IF; rl is the run level from ID onward
    task automatic instr(input logic [5:0] op, input logic [5:0] fn, input int if_wait,
                         input int mem_wait, input logic rl);
        int k;
        k = kind(op, fn);
        for (int i = 0; i < if_wait; i++) cyc(1'b1, op, fn, 1'b0, 6'd1, 1'b1, 1'b0, 1'b0);
        cyc(1'b1, op, fn, 1'b1, 6'd1, 1'b0, 1'b0, 1'b0);
        cyc(rl, op, fn, 1'b0, 6'd0, 1'b0, k == K_J, k == K_ILL);
        if (k == K_J || k == K_ILL) return;
        cyc(rl, op, fn, 1'b0, 6'd2, 1'b0, k == K_JR, 1'b0);
        if (k == K_JR) return;
        if (k == K_LW || k == K_SW) begin
            for (int i = 0; i < mem_wait; i++) cyc(rl, op, fn, 1'b0, 6'd3, 1'b1, 1'b0, 1'b0);
            cyc(rl, op, fn, 1'b1, 6'd3, 1'b0, k == K_SW, 1'b0);
            if (k == K_SW) return;
        end else if (k == K_BR) begin
            cyc(rl, op, fn, 1'b0, 6'd3, 1'b0, 1'b0, 1'b0);
        end
        cyc(rl, op, fn, 1'b0, 6'd4, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        reset         = 1'b1;
        exp_ret       = '0;
        bus.run       = 1'b1;
        bus.opcode    = OP_LW;
        bus.funct     = '0;
        bus.mem_ready = 1'b1;

        // Reset holds HALT regardless of clock edges with run high
        repeat (2) @(negedge clk);
        chk("rst_state",   {26'd0, bus.state},      32'd5);
        chk("rst_retired", {16'd0, bus.retired},    32'd0);
        chk("rst_stall",   {31'd0, bus.stall},      32'd0);
        chk("rst_done",    {31'd0, bus.instr_done}, 32'd0);
        chk("rst_ill",     {31'd0, bus.illegal},    32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // LW: 5,1,0,2,3,4,1
        cyc(1'b1, OP_LW, 6'd0, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0);
        instr(OP_LW, 6'd0, 0, 0, 1'b1);
        // SW with three not-ready MEM cycles, then an IF wait
        instr(OP_SW, 6'd0, 0, 3, 1'b1);
        instr(OP_LW, 6'd0, 2, 1, 1'b1);
        // JR then unsupported funct
        instr(OP_RTYPE, FN_JR, 0, 0, 1'b1);
        instr(OP_RTYPE, 6'd0, 0, 0, 1'b1);
        instr(OP_BEQ, 6'd0, 0, 0, 1'b1);
        instr(OP_BNE, 6'd0, 0, 0, 1'b1);
        instr(OP_J, 6'd0, 0, 0, 1'b1);
        instr(OP_JAL, 6'd0, 0, 0, 1'b1);
        instr(OP_XORI, 6'd0, 0, 0, 1'b1);
        instr(OP_RTYPE, FN_ADD, 0, 0, 1'b1);
        instr(OP_RTYPE, FN_SUB, 0, 0, 1'b1);
        instr(OP_RTYPE, FN_SLT, 1, 0, 1'b1);
        instr(OP_BAD, 6'd0, 0, 0, 1'b1);

        // run drops after ID of ADDI: instruction completes, then parks in HALT
        instr(OP_ADDI, 6'd0, 0, 0, 1'b0);
        repeat (3) cyc(1'b0, OP_ADDI, 6'd0, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, OP_J, 6'd0, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a stalled LW MEM
        cyc(1'b1, OP_LW, 6'd0, 1'b1, 6'd1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, OP_LW, 6'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, OP_LW, 6'd0, 1'b0, 6'd2, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, OP_LW, 6'd0, 1'b0, 6'd3, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("midrst_state",   {26'd0, bus.state},      32'd5);
        chk("midrst_retired", {16'd0, bus.retired},    32'd0);
        chk("midrst_done",    {31'd0, bus.instr_done}, 32'd0);
        chk("midrst_stall",   {31'd0, bus.stall},      32'd0);
        exp_ret = '0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b1, OP_J, 6'd0, 1'b1, 6'd5, 1'b0, 1'b0, 1'b0);

        // 65535 back-to-back J instructions bring retired to 0xFFFF
        bus.run       = 1'b1;
        bus.opcode    = OP_J;
        bus.funct     = '0;
        bus.mem_ready = 1'b1;
        repeat (2 * 65535) @(posedge clk);
        #1;
        exp_ret = 16'hFFFF;
        chk("preload_retired", {16'd0, bus.retired}, 32'h0000_FFFF);
        chk("preload_state",   {26'd0, bus.state},   32'd1);
        instr(OP_J, 6'd0, 0, 0, 1'b1);
        cyc(1'b1, OP_J, 6'd0, 1'b0, 6'd1, 1'b1, 1'b0, 1'b0);
        chk("wrap_retired", {16'd0, bus.retired}, 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
